buf_read_arbiter: RTL and testbench
===================================

BUF_READ_ARBITER -- requirements
Module: buf_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing one buffer-bank read port; legal range 2..8.
REQ-002 Parameter ADDR_W, default 11: bank word-address width.
REQ-003 Parameter DATA_W, default 512: bank data width.
REQ-004 Parameter RD_LATENCY, default 2: cycles from bank_avalid to bank_valid; legal range 1..8.
REQ-005 aclk  input  1  clock; all logic rising-edge.
REQ-006 areset  input  1  asynchronous, active-high reset.
REQ-007 req_avalid  input  NUM_REQ  per-requester read request.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 req_lock  input  NUM_REQ  per-requester burst-lock request.
REQ-010 req_grant  output  NUM_REQ  one-hot grant; a request is accepted in any cycle where req_avalid[i] and req_grant[i] are both high.
REQ-011 rsp_valid  output  NUM_REQ  per-requester read-data valid.
REQ-012 rsp_data  output  DATA_W  read data, shared by all requesters.
REQ-013 bank_avalid  output  1  read strobe to the bank.
REQ-014 bank_addr  output  ADDR_W  read address to the bank.
REQ-015 bank_valid  input  1  bank read-data valid.
REQ-016 bank_data  input  DATA_W  bank read data.
REQ-017 busy  output  1  high while any read is in flight or a lock is held.
REQ-018 rsp_err  output  1  sticky flag for a read-response protocol violation.

Function
REQ-019 req_grant SHALL be combinational: at most one bit high, and only to a requester with req_avalid high.
REQ-020 Without a lock, the grant SHALL go round-robin; the priority pointer SHALL move to (i+1) mod NUM_REQ after an acceptance by requester i, and it SHALL reset to 0.
REQ-021 For a request accepted in cycle T, bank_avalid SHALL be high in cycle T+1 with bank_addr equal to the accepted req_addr; with no acceptance, bank_avalid SHALL be 0 and bank_addr SHALL hold.
REQ-022 A RD_LATENCY+1 deep shift register of {valid, requester ID} SHALL track each issued read, aligned to the cycle its bank_valid is expected.
REQ-023 For a read accepted in cycle T, when the tracked entry is valid and bank_valid is high in cycle T+1+RD_LATENCY:
- rsp_valid[ID] SHALL be high in cycle T+2+RD_LATENCY;
- rsp_data SHALL equal the registered bank_data;
- all other rsp_valid bits SHALL be 0.
REQ-024 Throughput SHALL be one read per cycle, and responses SHALL return in acceptance order.
REQ-025 If bank_valid is high while the tracked entry is invalid, or the entry is valid while bank_valid is low:
- rsp_err SHALL set and stay set until reset;
- no rsp_valid SHALL be produced for that slot.
REQ-026 busy SHALL be the OR of all tracker valid bits and the lock-held state.
REQ-027 Simultaneous requests from every requester SHALL each be granted within NUM_REQ cycles when no lock is held.

Reset
REQ-028 areset SHALL clear the following asynchronously: req_grant, rsp_valid, rsp_data, bank_avalid, bank_addr, busy, rsp_err, the priority pointer, the tracker and the lock state.
REQ-029 For RD_LATENCY+1 cycles after areset deasserts, bank_valid SHALL be ignored (no response, no rsp_err); a drain counter SHALL implement this window.
REQ-030 Reset mid-operation SHALL drop all in-flight reads silently.

Configuration
REQ-031 Macro BUF_ARB_LOCK_EN defined: when a request from requester i is accepted with req_lock[i] high, the grant SHALL remain exclusively with i for as long as req_lock[i] stays high.
REQ-032 Under BUF_ARB_LOCK_EN, on lock release the pointer SHALL move to (i+1) mod NUM_REQ; while locked, other requesters SHALL receive no grant even if i idles.
REQ-033 Macro BUF_ARB_LOCK_EN undefined: req_lock SHALL be ignored, no lock state SHALL be synthesised, and busy SHALL reflect the tracker only.

Verification (NUM_REQ=3, RD_LATENCY=2)
REQ-034 Requester 1 reads 0x005 at cycle 0 -> bank_avalid=1 with addr 0x005 at cycle 1; bank_valid with 0xA5.. at cycle 3 -> rsp_valid=3'b010 and rsp_data=0xA5.. at cycle 4.
REQ-035 All three requesters hold req_avalid for 6 cycles -> grant sequence 0,1,2,0,1,2, with responses in the same order.
REQ-036 With BUF_ARB_LOCK_EN, requester 2 holds req_lock for 4 accepts while 0 and 1 request -> grants 2,2,2,2, then 0, then 1.
REQ-037 bank_valid pulses with the tracker empty -> rsp_err=1 and stays 1; rsp_valid stays 0.
REQ-038 Two reads in flight, then a one-cycle areset pulse, then bank_valid at 1 and 2 cycles after release -> all outputs 0, rsp_err=0, no rsp_valid.
REQ-039 Requester 0 streams addresses 0..7 back-to-back -> 8 consecutive rsp_valid[0] pulses, starting 4 cycles after the first accept, with data in address order.

Source files
------------

// File: rtl/buf_read_arbiter.sv
// buf_read_arbiter: round-robin arbiter that shares one buffer-bank read port
// between NUM_REQ requesters. Issues one read per cycle, tracks each in-flight
// read through a RD_LATENCY+1 deep {valid, id} shift register and routes the
// bank's read data back to the requester that issued it. A sticky error flag
// catches bank_valid pulses that do not line up with a tracked read.
// Optional feature: define BUF_ARB_LOCK_EN to let a requester hold the grant
// (burst lock) for as long as its req_lock stays high.
module buf_read_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 512,
   parameter int RD_LATENCY = 2
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [NUM_REQ-1:0]        req_avalid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0]        req_lock,
   output logic [NUM_REQ-1:0]        req_grant,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      bank_avalid,
   output logic [ADDR_W-1:0]         bank_addr,
   input  logic                      bank_valid,
   input  logic [DATA_W-1:0]         bank_data,
   output logic                      busy,
   output logic                      rsp_err
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int DEPTH = RD_LATENCY + 1;
   localparam int CNT_W = $clog2(RD_LATENCY + 2);
   localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(RD_LATENCY + 1);

   logic [ID_W-1:0]              ptr_q, ptr_d;
   logic                         bank_avalid_q, bank_avalid_d;
   logic [ADDR_W-1:0]            bank_addr_q, bank_addr_d;
   logic [DEPTH-1:0]             trk_vld_q, trk_vld_d;
   logic [DEPTH-1:0][ID_W-1:0]   trk_id_q, trk_id_d;
   logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]            rsp_data_q, rsp_data_d;
   logic                         rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]             drain_q, drain_d;

   logic [NUM_REQ-1:0]           rr_grant;
   logic [ID_W-1:0]              rr_id;
   logic                         rr_found;
   logic [ID_W:0]                rr_sum;
   logic [NUM_REQ-1:0]           grant_c;
   logic [ID_W-1:0]              gnt_id;
   logic                         accept;
   logic [ADDR_W-1:0]            sel_addr;
   logic                         drain_active;
   logic                         slot_vld;
   logic [ID_W-1:0]              slot_id;
   logic                         lock_held;

   // Round-robin search: first requesting index at or after the pointer
   always_comb begin
      rr_grant = '0;
      rr_id    = '0;
      rr_found = 1'b0;
      rr_sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rr_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (rr_sum >= (ID_W+1)'(NUM_REQ)) rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
         if (!rr_found && req_avalid[rr_sum[ID_W-1:0]]) begin
            rr_grant[rr_sum[ID_W-1:0]] = 1'b1;
            rr_id    = rr_sum[ID_W-1:0];
            rr_found = 1'b1;
         end
      end
   end

`ifdef BUF_ARB_LOCK_EN
   logic            lock_q, lock_d;
   logic [ID_W-1:0] lock_id_q, lock_id_d;
   logic            lock_active;

   // A lock stays in force only while its owner keeps req_lock high
   always_comb begin
      lock_active = lock_q && req_lock[lock_id_q];
      grant_c     = rr_grant;
      gnt_id      = rr_id;
      if (lock_active) begin
         grant_c = req_avalid[lock_id_q] ? (NUM_REQ'(1) << lock_id_q) : '0;
         gnt_id  = lock_id_q;
      end
   end

   // Next lock state: hold, capture on a locked acceptance, or release
   always_comb begin
      lock_d    = 1'b0;
      lock_id_d = lock_id_q;
      if (lock_active) begin
         lock_d = 1'b1;
      end else if (accept && req_lock[gnt_id]) begin
         lock_d    = 1'b1;
         lock_id_d = gnt_id;
      end
   end

   // Lock state register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

   assign lock_held = lock_q;
`else
   logic unused_lock;

   // Without the lock feature the plain round-robin result is the grant
   always_comb begin
      grant_c = rr_grant;
      gnt_id  = rr_id;
   end

   assign unused_lock = ^req_lock;
   assign lock_held   = 1'b0;
`endif

   assign req_grant = areset ? '0 : grant_c;
   assign accept    = |req_grant;

   // Address mux for the granted requester
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_id == ID_W'(i)) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
   end

   assign drain_active = (drain_q != '0);
   assign slot_vld     = trk_vld_q[DEPTH-1];
   assign slot_id      = trk_id_q[DEPTH-1];

   // Next-state: pointer, bank request, tracker shift, response and error
   always_comb begin
      ptr_d         = ptr_q;
      bank_avalid_d = accept;
      bank_addr_d   = bank_addr_q;
      trk_vld_d     = {trk_vld_q[DEPTH-2:0], accept};
      trk_id_d      = {trk_id_q[DEPTH-2:0], gnt_id};
      rsp_valid_d   = '0;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      drain_d       = drain_active ? drain_q - CNT_W'(1) : drain_q;
      if (accept) begin
         bank_addr_d = sel_addr;
         ptr_d       = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
      end
      if (!drain_active) begin
         if (slot_vld && bank_valid) begin
            rsp_valid_d = NUM_REQ'(1) << slot_id;
            rsp_data_d  = bank_data;
         end else if (slot_vld != bank_valid) begin
            rsp_err_d = 1'b1;
         end
      end
   end

   // Main state register; reset drops every in-flight read
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         ptr_q         <= '0;
         bank_avalid_q <= 1'b0;
         bank_addr_q   <= '0;
         trk_vld_q     <= '0;
         trk_id_q      <= '0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
         rsp_err_q     <= 1'b0;
         drain_q       <= DRAIN_INIT;
      end else begin
         ptr_q         <= ptr_d;
         bank_avalid_q <= bank_avalid_d;
         bank_addr_q   <= bank_addr_d;
         trk_vld_q     <= trk_vld_d;
         trk_id_q      <= trk_id_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
         drain_q       <= drain_d;
      end
   end

   assign bank_avalid = bank_avalid_q;
   assign bank_addr   = bank_addr_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign busy        = (|trk_vld_q) | lock_held;

endmodule

// File: tb/tb_buf_read_arbiter.sv
// tb_buf_read_arbiter: randomized bench for buf_read_arbiter with a reference
// model of the round-robin grant, a bank model that answers each issued read
// RD_LATENCY cycles later, and a response scoreboard. Directed sections cover
// the error flag, the reset drain window and (with BUF_ARB_LOCK_EN) the lock.
module tb_buf_read_arbiter;

   localparam int N    = 3;
   localparam int AW   = 11;
   localparam int DW   = 512;
   localparam int RL   = 2;
   localparam int MAXC = 4096;

   logic            aclk = 1'b0;
   logic            areset = 1'b0;
   logic [N-1:0]    req_avalid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_lock;
   logic [N-1:0]    req_grant;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            bank_avalid;
   logic [AW-1:0]   bank_addr;
   logic            bank_valid;
   logic [DW-1:0]   bank_data;
   logic            busy;
   logic            rsp_err;

   typedef struct {
      int            cyc;
      int            id;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          rspq[$];
   int            cyc = 0;
   int            n_checks = 0;
   int            n_fail = 0;
   bit            mon_en = 1'b0;
   int            m_ptr;
   bit            pend_v;
   int            pend_id;
   logic [AW-1:0] pend_addr;
   logic [AW-1:0] last_addr;
   int            last_issue;
   bit            sched_v [0:MAXC-1];
   logic [DW-1:0] sched_d [0:MAXC-1];

   buf_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)) dut (
      .aclk(aclk), .areset(areset),
      .req_avalid(req_avalid), .req_addr(req_addr), .req_lock(req_lock),
      .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .bank_avalid(bank_avalid), .bank_addr(bank_addr),
      .bank_valid(bank_valid), .bank_data(bank_data),
      .busy(busy), .rsp_err(rsp_err)
   );

   // Free-running clock
   always #5 aclk = ~aclk;

   // Cycle index, advanced on every rising edge
   always @(posedge aclk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = {a, 21'(a * 13 + i + 5)};
      return d;
   endfunction

   task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_model();
      rspq.delete();
      m_ptr      = 0;
      pend_v     = 1'b0;
      pend_id    = 0;
      pend_addr  = '0;
      last_addr  = '0;
      last_issue = -100;
   endtask

   task automatic apply_stimulus(input logic [N-1:0] av, input logic [N*AW-1:0] ad, input bit force_bv);
      @(posedge aclk);
      #1;
      if (cyc >= MAXC - RL - 4) begin
         $display("[TB] FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC - RL - 4);
         $fatal(1, "[TB] cycle budget exhausted");
      end
      req_avalid = av;
      req_addr   = ad;
      bank_valid = force_bv | sched_v[cyc];
      bank_data  = sched_v[cyc] ? sched_d[cyc] : {16{$urandom()}};
   endtask

   // Monitor: bank-side checks, response scoreboard, and grant reference model
   always @(negedge aclk) begin
      if (mon_en) begin
         logic [N-1:0] exp_g;
         logic [N-1:0] exp_v;
         int           id;
         rsp_t         r;
         check_output("bank_avalid", bank_avalid, pend_v);
         if (pend_v) begin
            check_output("bank_addr", bank_addr, pend_addr);
            last_addr  = pend_addr;
            last_issue = cyc;
            sched_v[cyc+RL] = 1'b1;
            sched_d[cyc+RL] = data_of(pend_addr);
            r.cyc  = cyc + RL + 1;
            r.id   = pend_id;
            r.data = data_of(pend_addr);
            rspq.push_back(r);
         end else begin
            check_output("bank_addr_hold", bank_addr, last_addr);
         end
         check_output("busy", busy, (cyc - last_issue) <= RL);
         if (rsp_valid != '0) begin
            if (rspq.size() == 0) begin
               check_output("rsp_unexpected", rsp_valid, '0);
            end else begin
               r = rspq.pop_front();
               exp_v = '0;
               exp_v[r.id] = 1'b1;
               check_output("rsp_cycle", cyc, r.cyc);
               check_output("rsp_valid", rsp_valid, exp_v);
               check_output("rsp_data", rsp_data, r.data);
            end
         end else if (rspq.size() > 0 && rspq[0].cyc <= cyc) begin
            r = rspq.pop_front();
            exp_v = '0;
            exp_v[r.id] = 1'b1;
            check_output("rsp_missing", rsp_valid, exp_v);
         end
         check_output("rsp_err_clear", rsp_err, 1'b0);
         exp_g  = '0;
         id     = 0;
         pend_v = 1'b0;
         for (int k = 0; k < N; k++) begin
            id = (m_ptr + k) % N;
            if (req_avalid[id]) begin
               exp_g[id] = 1'b1;
               break;
            end
         end
         check_output("req_grant", req_grant, exp_g);
         if (exp_g != '0) begin
            pend_v    = 1'b1;
            pend_id   = id;
            pend_addr = req_addr[id*AW +: AW];
            m_ptr     = (id + 1) % N;
         end
      end
   end

   initial begin
      logic [N*AW-1:0] ad;
      logic [N-1:0]    av;
      for (int i = 0; i < MAXC; i++) sched_v[i] = 1'b0;
      req_avalid = '0;
      req_addr   = '0;
      req_lock   = '0;
      bank_valid = 1'b0;
      bank_data  = '0;
      reset_model();

      // Asynchronous reset before any clock edge
      #2 areset = 1'b1;
      #1;
      check_output("reset_grant", req_grant, '0);
      check_output("reset_rsp_valid", rsp_valid, '0);
      check_output("reset_rsp_data", rsp_data, '0);
      check_output("reset_bank_avalid", bank_avalid, 1'b0);
      check_output("reset_bank_addr", bank_addr, '0);
      check_output("reset_busy", busy, 1'b0);
      check_output("reset_rsp_err", rsp_err, 1'b0);
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      mon_en = 1'b1;

      // Random request patterns
      for (int c = 0; c < 400; c++) begin
         av = N'($urandom());
         if ($urandom_range(3) == 0) av = '1;
         for (int i = 0; i < N; i++) ad[i*AW +: AW] = AW'($urandom());
         apply_stimulus(av, ad, 1'b0);
      end

      // All requesters at once for six cycles
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++) ad[i*AW +: AW] = AW'(16 * c + i);
         apply_stimulus('1, ad, 1'b0);
      end

      // Requester 0 streams addresses 0..7 back-to-back
      for (int c = 0; c < 8; c++) begin
         ad = '0;
         ad[0 +: AW] = AW'(c);
         apply_stimulus(N'(1), ad, 1'b0);
      end

      for (int c = 0; c < RL + 6; c++) apply_stimulus('0, '0, 1'b0);
      check_output("rspq_drained", rspq.size(), 0);
      mon_en = 1'b0;

      // bank_valid with nothing in flight sets a sticky error
      apply_stimulus('0, '0, 1'b1);
      apply_stimulus('0, '0, 1'b0);
      @(negedge aclk);
      check_output("err_set", rsp_err, 1'b1);
      check_output("err_no_rsp", rsp_valid, '0);
      for (int c = 0; c < 4; c++) apply_stimulus('0, '0, 1'b0);
      @(negedge aclk);
      check_output("err_sticky", rsp_err, 1'b1);
      check_output("err_sticky_no_rsp", rsp_valid, '0);

      // Two reads in flight, then a one-cycle reset, then stray bank_valid
      apply_stimulus(N'(1), {N{AW'(3)}}, 1'b0);
      apply_stimulus(N'(1), {N{AW'(4)}}, 1'b0);
      @(posedge aclk);
      #1;
      areset     = 1'b1;
      req_avalid = '0;
      @(negedge aclk);
      check_output("midrst_bank_avalid", bank_avalid, 1'b0);
      check_output("midrst_busy", busy, 1'b0);
      check_output("midrst_rsp_err", rsp_err, 1'b0);
      check_output("midrst_rsp_data", rsp_data, '0);
      @(posedge aclk);
      #1 areset = 1'b0;
      apply_stimulus('0, '0, 1'b1);
      apply_stimulus('0, '0, 1'b1);
      for (int c = 0; c < 6; c++) begin
         @(negedge aclk);
         check_output("drain_rsp_valid", rsp_valid, '0);
         check_output("drain_rsp_err", rsp_err, 1'b0);
         check_output("drain_busy", busy, 1'b0);
         apply_stimulus('0, '0, 1'b0);
      end

`ifdef BUF_ARB_LOCK_EN
      // Requester 2 locks for four accepts, idles once, then releases
      begin
         logic [N-1:0] lk_av [7];
         logic [N-1:0] lk_lk [7];
         logic [N-1:0] lk_g  [7];
         lk_av = '{3'b100, 3'b111, 3'b011, 3'b111, 3'b111, 3'b111, 3'b011};
         lk_lk = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
         lk_g  = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b100, 3'b001, 3'b010};
         @(posedge aclk);
         #1 areset = 1'b1;
         @(posedge aclk);
         #1 areset = 1'b0;
         for (int c = 0; c < 7; c++) begin
            apply_stimulus(lk_av[c], '0, 1'b0);
            req_lock = lk_lk[c];
            @(negedge aclk);
            check_output($sformatf("lock_grant_%0d", c), req_grant, lk_g[c]);
         end
         req_lock = '0;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
